rom_port_arbiter: RTL and testbench
===================================

# rom_port_arbiter

Two-requester arbiter and sequencer for the single read port of the combinational instruction ROM. It shares that port between the instruction-fetch stage and the data-load path, and translates and validates byte addresses against the text segment. Responses are returned as registered, tagged pulses. The block sits between the fetch/load units and the ROM and is the ROM's only driver.

## Interface
- DATA_WIDTH, 32, ROM word and data width
- DEPTH, 64, ROM words
- BASE_ADDR, 32'h0040_0000, byte address of ROM word 0
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- flush  in  1  fetch redirect; kills the not-yet-read fetch transaction
- if_req_valid  in  1  fetch request
- if_req_addr  in  32  fetch byte address
- if_req_ready  out  1  fetch request accepted this cycle
- ld_req_valid  in  1  load request
- ld_req_addr  in  32  load byte address
- ld_req_ready  out  1  load request accepted this cycle
- rom_addr  out  32  byte address to ROM port
- rom_q  in  DATA_WIDTH  ROM read data, combinational from rom_addr
- if_rsp_valid / ld_rsp_valid  out  1  one-cycle response pulse
- if_rsp_data / ld_rsp_data  out  DATA_WIDTH  read word
- if_rsp_err / ld_rsp_err  out  1  address fault

## Operation
- Pipeline has two registered stages: A holds the accepted address, owner and error flag; R holds the response. One transaction is accepted per cycle in total.
- Handshake:
  - A request is accepted when valid and ready are both high in the same cycle.
  - Ready is combinational and goes high only for the arbitration winner; both readies are never high together.
  - Requesters hold valid and addr stable until accepted.
- Arbitration is round-robin using a 1-bit pointer rr (0 gives fetch priority, 1 gives load priority).
  - rr only matters when both requests are valid.
  - After a fetch grant, rr goes to 1; after a load grant, rr goes to 0. rr is unchanged when there is no grant.
- Fault check at acceptance; the fault is set if any of the following holds:
  - addr < BASE_ADDR
  - addr >= BASE_ADDR + 4*DEPTH (computed in 33 bits, no wrap)
  - addr[1:0] != 0
- ROM drive:
  - When A is valid and not faulted, rom_addr = the A address.
  - Otherwise rom_addr = BASE_ADDR.
- Response:
  - At the edge closing a cycle where A is valid, R captures rom_q, or 0 if faulted, along with err and owner.
  - R then pulses the matching *_rsp_valid for exactly one cycle.
  - Response consumers have no backpressure; they must take the data on the pulse.
- Flush:
  - During a flush cycle, if_req_ready = 0; a load may still be granted.
  - At the edge, a fetch entry in A is discarded: no R capture and no if_rsp_valid.
  - A fetch response already in R during the flush cycle is still delivered.
  - A load entry is never affected by flush.
- Response data and err registers update only when the corresponding valid is set; otherwise they hold their value.

## Timing
- Latency: accepted in cycle t, in stage A at t+1, response valid at t+2.
- Back-to-back acceptances give back-to-back responses, in grant order.
- Reset is asynchronous and takes effect immediately. All of the following go to 0:
  - A and R valid bits
  - rr
  - all *_rsp_valid, *_rsp_data and *_rsp_err outputs
  - rom_addr goes to BASE_ADDR.
  - Reset mid-transaction drops all in-flight requests silently.
- Readies depend only on the request valids, rr and flush, with no reset dependency other than through rr.

## Test plan
- Single fetch at 0x0040_0008 in cycle 1:
  - if_req_ready = 1 in cycle 1.
  - rom_addr = 0x0040_0008 in cycle 2.
  - if_rsp_valid = 1 in cycle 3 with data = ROM word 2 and err = 0.
- Both requests valid continuously after reset, fetch 0x0040_0000 and load 0x0040_0004:
  - Grants alternate IF, LD, IF, LD.
  - Responses alternate starting in cycle 3, one per cycle.
- Faults:
  - Load at 0x003F_FFFC gives ld_rsp_err = 1 and data = 0.
  - Load at 0x0040_0100 (DEPTH = 64) gives err = 1.
  - Fetch at 0x0040_0002 gives err = 1.
  - In every fault case rom_addr = 0x0040_0000.
- Flush:
  - Fetch accepted in cycle 5, flush = 1 in cycle 6: no if_rsp_valid in cycle 7.
  - A fetch accepted in cycle 4 still responds in cycle 6.
  - A load request in cycle 6 is granted while if_req_ready = 0.
- Reset:
  - rst_n driven low mid-cycle with A and R full: all valids clear immediately and rom_addr = 0x0040_0000.
  - No response appears after release.
  - The first grant after release goes to fetch on a tie.

Source files
------------

// File: rtl/rom_port_arbiter.sv
// rom_port_arbiter: shares the single instruction-ROM read port between fetch and
// load with round-robin arbitration, text-segment address checking and tagged responses.
module rom_port_arbiter #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned DEPTH      = 64,
   parameter logic [31:0] BASE_ADDR  = 32'h0040_0000
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  flush_i,
   input  logic                  if_req_valid_i,
   input  logic [31:0]           if_req_addr_i,
   output logic                  if_req_ready_o,
   input  logic                  ld_req_valid_i,
   input  logic [31:0]           ld_req_addr_i,
   output logic                  ld_req_ready_o,
   output logic [31:0]           rom_addr_o,
   input  logic [DATA_WIDTH-1:0] rom_q_i,
   output logic                  if_rsp_valid_o,
   output logic [DATA_WIDTH-1:0] if_rsp_data_o,
   output logic                  if_rsp_err_o,
   output logic                  ld_rsp_valid_o,
   output logic [DATA_WIDTH-1:0] ld_rsp_data_o,
   output logic                  ld_rsp_err_o
);

   typedef enum logic {
      OwnerFetch = 1'b0,
      OwnerLoad  = 1'b1
   } owner_e;

   localparam logic [32:0] BaseExt  = {1'b0, BASE_ADDR};
   localparam logic [32:0] LimitExt = BaseExt + 33'(4 * DEPTH);

   logic                  rr_q, rr_d;
   logic                  aValid_q, aValid_d;
   logic [31:0]           aAddr_q, aAddr_d;
   owner_e                aOwner_q, aOwner_d;
   logic                  aErr_q, aErr_d;
   logic                  ifRspValid_q, ifRspValid_d;
   logic                  ldRspValid_q, ldRspValid_d;
   logic [DATA_WIDTH-1:0] ifRspData_q, ldRspData_q;
   logic                  ifRspErr_q, ldRspErr_q;

   logic                  ifGrant, ldGrant;
   logic [31:0]           reqAddr;
   logic [32:0]           reqAddrExt;
   logic                  reqErr;
   logic                  rCapture;
   logic [DATA_WIDTH-1:0] rData;

   // A flushed fetch never competes, so a load may win the port in that cycle.
   always_comb begin
      ifGrant = if_req_valid_i & ~flush_i & (~ld_req_valid_i | ~rr_q);
      ldGrant = ld_req_valid_i & ~ifGrant;
   end

   assign if_req_ready_o = ifGrant;
   assign ld_req_ready_o = ldGrant;

   always_comb begin
      reqAddr    = ifGrant ? if_req_addr_i : ld_req_addr_i;
      reqAddrExt = {1'b0, reqAddr};
      reqErr     = (reqAddrExt < BaseExt) | (reqAddrExt >= LimitExt) | (reqAddr[1:0] != 2'b00);
   end

   always_comb begin
      rr_d     = rr_q;
      aValid_d = ifGrant | ldGrant;
      aAddr_d  = aAddr_q;
      aOwner_d = aOwner_q;
      aErr_d   = aErr_q;
      if (ifGrant) begin
         rr_d = 1'b1;
      end else if (ldGrant) begin
         rr_d = 1'b0;
      end
      if (ifGrant | ldGrant) begin
         aAddr_d  = reqAddr;
         aOwner_d = ifGrant ? OwnerFetch : OwnerLoad;
         aErr_d   = reqErr;
      end
   end

   // A flush kills only a fetch sitting in A; loads always complete.
   always_comb begin
      rCapture     = aValid_q & ~(flush_i & (aOwner_q == OwnerFetch));
      ifRspValid_d = rCapture & (aOwner_q == OwnerFetch);
      ldRspValid_d = rCapture & (aOwner_q == OwnerLoad);
      rData        = aErr_q ? '0 : rom_q_i;
   end

   assign rom_addr_o = (aValid_q & ~aErr_q) ? aAddr_q : BASE_ADDR;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rr_q         <= 1'b0;
         aValid_q     <= 1'b0;
         aAddr_q      <= '0;
         aOwner_q     <= OwnerFetch;
         aErr_q       <= 1'b0;
         ifRspValid_q <= 1'b0;
         ldRspValid_q <= 1'b0;
         ifRspData_q  <= '0;
         ldRspData_q  <= '0;
         ifRspErr_q   <= 1'b0;
         ldRspErr_q   <= 1'b0;
      end else begin
         rr_q         <= rr_d;
         aValid_q     <= aValid_d;
         aAddr_q      <= aAddr_d;
         aOwner_q     <= aOwner_d;
         aErr_q       <= aErr_d;
         ifRspValid_q <= ifRspValid_d;
         ldRspValid_q <= ldRspValid_d;
         if (ifRspValid_d) begin
            ifRspData_q <= rData;
            ifRspErr_q  <= aErr_q;
         end
         if (ldRspValid_d) begin
            ldRspData_q <= rData;
            ldRspErr_q  <= aErr_q;
         end
      end
   end

   assign if_rsp_valid_o = ifRspValid_q;
   assign if_rsp_data_o  = ifRspData_q;
   assign if_rsp_err_o   = ifRspErr_q;
   assign ld_rsp_valid_o = ldRspValid_q;
   assign ld_rsp_data_o  = ldRspData_q;
   assign ld_rsp_err_o   = ldRspErr_q;

endmodule

// File: tb/tb_rom_port_arbiter.sv
// tb_rom_port_arbiter: directed and random traffic against a transaction-queue
// reference model of the ROM port arbiter.
module tb_rom_port_arbiter;

   localparam int unsigned DataWidth = 32;
   localparam int unsigned Depth     = 64;
   localparam logic [31:0] BaseAddr  = 32'h0040_0000;

   typedef struct {
      bit          isLoad;
      logic [31:0] addr;
      bit          err;
      int          due;
   } txn_t;

   logic                 clock = 1'b0;
   logic                 rstN;
   logic                 flush;
   logic                 ifValid, ldValid;
   logic [31:0]          ifAddr, ldAddr;
   logic                 ifReady, ldReady;
   logic [31:0]          romAddr;
   logic [DataWidth-1:0] romQ;
   logic                 ifRspValid, ldRspValid;
   logic [DataWidth-1:0] ifRspData, ldRspData;
   logic                 ifRspErr, ldRspErr;
   logic [31:0]          romOffset;

   logic [DataWidth-1:0] romMem [Depth];
   txn_t                 pipeQ [$];
   bit                   rr;
   int                   cycle;
   int                   errors;
   int                   checks;
   bit                   ifPend, ldPend;
   logic [31:0]          ifPendAddr, ldPendAddr;
   logic [DataWidth-1:0] lastIfData, lastLdData;
   bit                   lastIfErr, lastLdErr;

   rom_port_arbiter #(
      .DATA_WIDTH(DataWidth),
      .DEPTH(Depth),
      .BASE_ADDR(BaseAddr)
   ) dut (
      .clk_i(clock),
      .rst_ni(rstN),
      .flush_i(flush),
      .if_req_valid_i(ifValid),
      .if_req_addr_i(ifAddr),
      .if_req_ready_o(ifReady),
      .ld_req_valid_i(ldValid),
      .ld_req_addr_i(ldAddr),
      .ld_req_ready_o(ldReady),
      .rom_addr_o(romAddr),
      .rom_q_i(romQ),
      .if_rsp_valid_o(ifRspValid),
      .if_rsp_data_o(ifRspData),
      .if_rsp_err_o(ifRspErr),
      .ld_rsp_valid_o(ldRspValid),
      .ld_rsp_data_o(ldRspData),
      .ld_rsp_err_o(ldRspErr)
   );

   always #5 clock = ~clock;

   // Combinational ROM; an illegal address returns a marker word.
   always_comb begin
      romOffset = romAddr - BaseAddr;
      if (romAddr >= BaseAddr && romOffset < 32'(Depth * 4) && romAddr[1:0] == 2'b00) begin
         romQ = romMem[romOffset[7:2]];
      end else begin
         romQ = 32'hDEAD_BEEF;
      end
   end

   function automatic bit isFault(input logic [31:0] a);
      longint la;
      la = longint'(a);
      return (la < longint'(BaseAddr)) || (la >= longint'(BaseAddr) + 4 * Depth) || (la % 4 != 0);
   endfunction

   function automatic logic [DataWidth-1:0] romWord(input logic [31:0] a);
      int idx;
      idx = int'((a - BaseAddr) / 4);
      return romMem[idx];
   endfunction

   function automatic logic [31:0] randomAddr();
      int sel;
      sel = int'($urandom_range(0, 9));
      if (sel <= 5) return BaseAddr + 4 * $urandom_range(0, Depth - 1);
      if (sel == 6) return BaseAddr - 4;
      if (sel == 7) return BaseAddr + 4 * Depth;
      if (sel == 8) return BaseAddr + 4 * $urandom_range(0, Depth - 1) + $urandom_range(1, 3);
      return $urandom();
   endfunction

   task automatic checkVal(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s cycle=%0d observed=%h expected=%h", tag, cycle, observed, expected);
      end
   endtask

   // Compares every output of the current cycle, then advances the model past the next edge.
   task automatic checkOutput();
      bit          expIfRdy, expLdRdy, expIfV, expLdV;
      logic [31:0] expRom;
      txn_t        t;
      expIfRdy = ifValid && !flush && (!ldValid || !rr);
      expLdRdy = ldValid && !expIfRdy;
      expIfV   = 1'b0;
      expLdV   = 1'b0;
      if (pipeQ.size() > 0 && pipeQ[0].due == cycle) begin
         t = pipeQ.pop_front();
         if (t.isLoad) begin
            expLdV     = 1'b1;
            lastLdData = t.err ? '0 : romWord(t.addr);
            lastLdErr  = t.err;
         end else begin
            expIfV     = 1'b1;
            lastIfData = t.err ? '0 : romWord(t.addr);
            lastIfErr  = t.err;
         end
      end
      expRom = BaseAddr;
      if (pipeQ.size() > 0 && pipeQ[0].due == cycle + 1 && !pipeQ[0].err) expRom = pipeQ[0].addr;

      checkVal("if_req_ready", 32'(ifReady), 32'(expIfRdy));
      checkVal("ld_req_ready", 32'(ldReady), 32'(expLdRdy));
      checkVal("rom_addr", romAddr, expRom);
      checkVal("if_rsp_valid", 32'(ifRspValid), 32'(expIfV));
      checkVal("ld_rsp_valid", 32'(ldRspValid), 32'(expLdV));
      checkVal("if_rsp_data", ifRspData, lastIfData);
      checkVal("if_rsp_err", 32'(ifRspErr), 32'(lastIfErr));
      checkVal("ld_rsp_data", ldRspData, lastLdData);
      checkVal("ld_rsp_err", 32'(ldRspErr), 32'(lastLdErr));

      if (flush && pipeQ.size() > 0 && pipeQ[0].due == cycle + 1 && !pipeQ[0].isLoad) begin
         void'(pipeQ.pop_front());
      end
      if (expIfRdy) begin
         t = '{isLoad: 1'b0, addr: ifAddr, err: isFault(ifAddr), due: cycle + 2};
         pipeQ.push_back(t);
         rr     = 1'b1;
         ifPend = 1'b0;
      end else if (expLdRdy) begin
         t = '{isLoad: 1'b1, addr: ldAddr, err: isFault(ldAddr), due: cycle + 2};
         pipeQ.push_back(t);
         rr     = 1'b0;
         ldPend = 1'b0;
      end
   endtask

   task automatic applyStimulus(input bit flushIn);
      @(negedge clock);
      flush   = flushIn;
      ifValid = ifPend;
      ifAddr  = ifPend ? ifPendAddr : $urandom();
      ldValid = ldPend;
      ldAddr  = ldPend ? ldPendAddr : $urandom();
      #1;
      checkOutput();
      cycle++;
   endtask

   task automatic resetModel();
      pipeQ.delete();
      rr         = 1'b0;
      ifPend     = 1'b0;
      ldPend     = 1'b0;
      lastIfData = '0;
      lastLdData = '0;
      lastIfErr  = 1'b0;
      lastLdErr  = 1'b0;
   endtask

   initial begin
      errors = 0;
      checks = 0;
      cycle  = 0;
      for (int i = 0; i < Depth; i++) romMem[i] = $urandom();
      resetModel();
      rstN    = 1'b0;
      flush   = 1'b0;
      ifValid = 1'b0;
      ldValid = 1'b0;
      ifAddr  = '0;
      ldAddr  = '0;
      repeat (2) @(negedge clock);
      rstN = 1'b1;

      // Idle after reset, then a lone fetch of word 2.
      applyStimulus(1'b0);
      ifPend = 1'b1; ifPendAddr = BaseAddr + 32'h8;
      applyStimulus(1'b0);
      repeat (3) applyStimulus(1'b0);

      // Both requesters valid continuously.
      for (int i = 0; i < 6; i++) begin
         if (!ifPend) begin ifPend = 1'b1; ifPendAddr = BaseAddr; end
         if (!ldPend) begin ldPend = 1'b1; ldPendAddr = BaseAddr + 32'h4; end
         applyStimulus(1'b0);
      end
      ifPend = 1'b0; ldPend = 1'b0;
      repeat (3) applyStimulus(1'b0);

      // Address faults and the last legal word.
      ldPend = 1'b1; ldPendAddr = BaseAddr - 32'h4;
      applyStimulus(1'b0);
      ldPend = 1'b1; ldPendAddr = BaseAddr + 32'h100;
      applyStimulus(1'b0);
      ifPend = 1'b1; ifPendAddr = BaseAddr + 32'h2;
      applyStimulus(1'b0);
      ldPend = 1'b1; ldPendAddr = BaseAddr + 32'hFC;
      applyStimulus(1'b0);
      repeat (3) applyStimulus(1'b0);

      // Flush kills the fetch in A while an older fetch still responds and a load wins.
      ifPend = 1'b1; ifPendAddr = BaseAddr + 32'h10;
      applyStimulus(1'b0);
      ifPend = 1'b1; ifPendAddr = BaseAddr + 32'h14;
      applyStimulus(1'b0);
      ifPend = 1'b1; ifPendAddr = BaseAddr + 32'h18;
      ldPend = 1'b1; ldPendAddr = BaseAddr + 32'h20;
      applyStimulus(1'b1);
      ifPend = 1'b0;
      repeat (3) applyStimulus(1'b0);

      // Random traffic with random flushes.
      for (int i = 0; i < 600; i++) begin
         if (!ifPend && $urandom_range(0, 2) == 0) begin ifPend = 1'b1; ifPendAddr = randomAddr(); end
         if (!ldPend && $urandom_range(0, 2) == 0) begin ldPend = 1'b1; ldPendAddr = randomAddr(); end
         applyStimulus($urandom_range(0, 7) == 0);
      end

      // Reset with A and R full; nothing may emerge afterwards.
      for (int i = 0; i < 3; i++) begin
         if (!ifPend) begin ifPend = 1'b1; ifPendAddr = BaseAddr + 4 * $urandom_range(0, Depth - 1); end
         if (!ldPend) begin ldPend = 1'b1; ldPendAddr = BaseAddr + 4 * $urandom_range(0, Depth - 1); end
         applyStimulus(1'b0);
      end
      @(posedge clock);
      #2;
      rstN    = 1'b0;
      ifValid = 1'b0;
      ldValid = 1'b0;
      flush   = 1'b0;
      #1;
      checkVal("reset_if_rsp_valid", 32'(ifRspValid), 32'h0);
      checkVal("reset_ld_rsp_valid", 32'(ldRspValid), 32'h0);
      checkVal("reset_rom_addr", romAddr, BaseAddr);
      checkVal("reset_if_rsp_data", ifRspData, 32'h0);
      checkVal("reset_ld_rsp_data", ldRspData, 32'h0);
      @(negedge clock);
      rstN = 1'b1;
      resetModel();
      cycle += 2;
      ifPend = 1'b1; ifPendAddr = BaseAddr + 32'h30;
      ldPend = 1'b1; ldPendAddr = BaseAddr + 32'h34;
      applyStimulus(1'b0);
      applyStimulus(1'b0);
      repeat (4) applyStimulus(1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
